// File: rtl/scalar_mult_ctrl.sv
// -----------------------------------------------------------------------------
// scalar_mult_ctrl
//
// Left-to-right double-and-add controller computing R = k*P on a prime-field
// short-Weierstrass curve. The block owns the accumulator point A and drives an
// external point-operation unit (add / double). It handles the cases that unit
// cannot: A at infinity, A == P (rerouted to a doubling) and A == -P (result is
// infinity, no request issued). Only equality compares are done here.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start                 one-cycle request, accepted only when idle
//   k                     scalar, latched on accepted start
//   px, py                base point P (affine, not infinity), latched on start
//   busy                  high from the cycle after accepted start until done
//   done                  one-cycle pulse, rx/ry/r_inf valid
//   rx, ry, r_inf         result point, held until the next result
//   op_start              one-cycle pulse issuing a point operation
//   op_dbl                1 = double a, 0 = add a + b
//   op_ax/op_ay/op_bx/op_by operands, stable from op_start until op_done
//   op_done               one-cycle pulse, op_rx/op_ry/op_inf valid
//   op_rx, op_ry, op_inf  point-operation result
// -----------------------------------------------------------------------------
module scalar_mult_ctrl #(
   parameter int n  = 231,
   parameter int KW = 231
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [KW-1:0] k,
   input  logic [n-1:0]  px,
   input  logic [n-1:0]  py,
   output logic          busy,
   output logic          done,
   output logic [n-1:0]  rx,
   output logic [n-1:0]  ry,
   output logic          r_inf,
   output logic          op_start,
   output logic          op_dbl,
   output logic [n-1:0]  op_ax,
   output logic [n-1:0]  op_ay,
   output logic [n-1:0]  op_bx,
   output logic [n-1:0]  op_by,
   input  logic          op_done,
   input  logic [n-1:0]  op_rx,
   input  logic [n-1:0]  op_ry,
   input  logic          op_inf
);

   localparam int IW = (KW > 1) ? $clog2(KW) : 1;

   typedef enum logic [3:0] {
      IDLE, SCAN, DBL_REQ, DBL_WAIT, ADD_CHK, ADD_REQ, ADD_WAIT, NEXT, FIN
   } state_t;

   state_t        state;
   logic [KW-1:0] k_q;
   logic [n-1:0]  p_x, p_y;
   logic [n-1:0]  a_x, a_y;
   logic          a_inf;
   logic [IW-1:0] idx;
   // Set when a doubling was issued from ADD_CHK because A == P; that doubling
   // already stands in for the add of this bit, so its result goes to NEXT.
   logic          dbl_then_next;

   // NOTE: every register here is state, so the whole block uses non-blocking
   // assignments; a blocking one would leak same-cycle values between branches.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         rx            <= '0;
         ry            <= '0;
         r_inf         <= 1'b1;
         op_start      <= 1'b0;
         op_dbl        <= 1'b0;
         op_ax         <= '0;
         op_ay         <= '0;
         op_bx         <= '0;
         op_by         <= '0;
         k_q           <= '0;
         p_x           <= '0;
         p_y           <= '0;
         a_x           <= '0;
         a_y           <= '0;
         a_inf         <= 1'b1;
         idx           <= '0;
         dbl_then_next <= 1'b0;
      end else begin
         // Pulses default low and are raised only on the transition that needs them.
         op_start <= 1'b0;
         done     <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  k_q   <= k;
                  p_x   <= px;
                  p_y   <= py;
                  a_x   <= '0;
                  a_y   <= '0;
                  a_inf <= 1'b1;
                  idx   <= IW'(KW - 1);
                  busy  <= 1'b1;
                  state <= SCAN;
               end
            end

            SCAN: begin
               // Doubling infinity is infinity, so skip the request entirely.
               if (a_inf) begin
                  state <= ADD_CHK;
               end else begin
                  op_start      <= 1'b1;
                  op_dbl        <= 1'b1;
                  op_ax         <= a_x;
                  op_ay         <= a_y;
                  dbl_then_next <= 1'b0;
                  state         <= DBL_REQ;
               end
            end

            DBL_REQ: state <= DBL_WAIT;

            DBL_WAIT: begin
               if (op_done) begin
                  a_x   <= op_inf ? '0 : op_rx;
                  a_y   <= op_inf ? '0 : op_ry;
                  a_inf <= op_inf;
                  state <= dbl_then_next ? NEXT : ADD_CHK;
               end
            end

            ADD_CHK: begin
               if (!k_q[idx]) begin
                  state <= NEXT;
               end else if (a_inf) begin
                  a_x   <= p_x;
                  a_y   <= p_y;
                  a_inf <= 1'b0;
                  state <= NEXT;
               end else if (a_x == p_x) begin
                  if (a_y == p_y) begin
                     // A == P: the add unit cannot handle it, so compute 2P instead.
                     op_start      <= 1'b1;
                     op_dbl        <= 1'b1;
                     op_ax         <= p_x;
                     op_ay         <= p_y;
                     dbl_then_next <= 1'b1;
                     state         <= DBL_REQ;
                  end else begin
                     // Same x, different y: A == -P, so A + P is infinity.
                     a_x   <= '0;
                     a_y   <= '0;
                     a_inf <= 1'b1;
                     state <= NEXT;
                  end
               end else begin
                  op_start <= 1'b1;
                  op_dbl   <= 1'b0;
                  op_ax    <= a_x;
                  op_ay    <= a_y;
                  op_bx    <= p_x;
                  op_by    <= p_y;
                  state    <= ADD_REQ;
               end
            end

            ADD_REQ: state <= ADD_WAIT;

            ADD_WAIT: begin
               if (op_done) begin
                  a_x   <= op_inf ? '0 : op_rx;
                  a_y   <= op_inf ? '0 : op_ry;
                  a_inf <= op_inf;
                  state <= NEXT;
               end
            end

            NEXT: begin
               if (idx == '0) begin
                  rx    <= a_inf ? '0 : a_x;
                  ry    <= a_inf ? '0 : a_y;
                  r_inf <= a_inf;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FIN;
               end else begin
                  idx   <= idx - 1'b1;
                  state <= SCAN;
               end
            end

            FIN: state <= IDLE;

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scalar_mult_ctrl
//
// Bench for scalar_mult_ctrl on the curve y^2 = x^3 + 2x + 3 mod 97 with
// P = (3,6) and 8-bit widths. A behavioural point-operation unit answers each
// op_start three cycles later. Expected results and expected op kinds are
// queued when a run is started and compared as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_scalar_mult_ctrl;

   localparam int NW   = 8;
   localparam int KWID = 8;
   localparam int PRIME = 97;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [KWID-1:0] k;
   logic [NW-1:0]   px, py;
   logic            busy, done, r_inf;
   logic [NW-1:0]   rx, ry;
   logic            op_start, op_dbl;
   logic [NW-1:0]   op_ax, op_ay, op_bx, op_by;
   logic            op_done = 1'b0;
   logic [NW-1:0]   op_rx   = '0;
   logic [NW-1:0]   op_ry   = '0;
   logic            op_inf  = 1'b0;

   scalar_mult_ctrl #(.n(NW), .KW(KWID)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .k        (k),
      .px       (px),
      .py       (py),
      .busy     (busy),
      .done     (done),
      .rx       (rx),
      .ry       (ry),
      .r_inf    (r_inf),
      .op_start (op_start),
      .op_dbl   (op_dbl),
      .op_ax    (op_ax),
      .op_ay    (op_ay),
      .op_bx    (op_bx),
      .op_by    (op_by),
      .op_done  (op_done),
      .op_rx    (op_rx),
      .op_ry    (op_ry),
      .op_inf   (op_inf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- curve math
   function automatic int md(input int v);
      md = ((v % PRIME) + PRIME) % PRIME;
   endfunction

   function automatic int inv(input int a);
      inv = 0;
      for (int i = 1; i < PRIME; i++)
         if (md(a * i) == 1) inv = i;
   endfunction

   function automatic void ec_dbl(input int x, input int y, output int xo, output int yo,
                                  output bit inf);
      int l;
      if (y == 0) begin
         xo = 0; yo = 0; inf = 1'b1;
      end else begin
         l   = md((3 * x * x + 2) * inv(md(2 * y)));
         xo  = md(l * l - 2 * x);
         yo  = md(l * (x - xo) - y);
         inf = 1'b0;
      end
   endfunction

   function automatic void ec_add(input int x1, input int y1, input int x2, input int y2,
                                  output int xo, output int yo, output bit inf);
      int l;
      if (x1 == x2) begin
         if (y1 == y2) ec_dbl(x1, y1, xo, yo, inf);
         else begin xo = 0; yo = 0; inf = 1'b1; end
      end else begin
         l   = md((y2 - y1) * inv(md(x2 - x1)));
         xo  = md(l * l - x1 - x2);
         yo  = md(l * (x1 - xo) - y1);
         inf = 1'b0;
      end
   endfunction

   // ---------------------------------------------------------- scoreboards
   typedef struct packed {
      logic [NW-1:0] rx;
      logic [NW-1:0] ry;
      logic          inf;
   } res_t;

   res_t sbq[$];
   bit   opq[$];   // expected op kinds in issue order, 1 = double

   // ------------------------------------------------ point-operation unit model
   // Keeps counting through reset so a stale op_done can land on an idle DUT.
   int op_cnt = 0;
   int pend_x, pend_y;
   bit pend_inf;

   always @(negedge clk) begin
      op_done = 1'b0;
      if (op_cnt > 0) begin
         op_cnt--;
         if (op_cnt == 0) begin
            op_done = 1'b1;
            op_rx   = NW'(pend_x);
            op_ry   = NW'(pend_y);
            op_inf  = pend_inf;
         end
      end
      if (op_start) begin
         check("op_start while op outstanding", 32'(op_cnt), 32'd0);
         if (opq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected op: got op_dbl=%0d expected no op", op_dbl);
         end else begin
            check("op kind (1=dbl)", 32'(op_dbl), 32'(opq.pop_front()));
         end
         if (op_dbl)
            ec_dbl(int'(op_ax), int'(op_ay), pend_x, pend_y, pend_inf);
         else
            ec_add(int'(op_ax), int'(op_ay), int'(op_bx), int'(op_by), pend_x, pend_y, pend_inf);
         op_cnt = 3;
      end
   end

   // ------------------------------------------------------------ vector table
   typedef struct packed {
      logic [KWID-1:0] k;
      logic [NW-1:0]   rx;
      logic [NW-1:0]   ry;
      logic            inf;
      logic [3:0]      nops;
      logic [15:0]     mask;   // bit i = 1 when the i-th op is a doubling
      logic [7:0]      lat;    // start-to-done cycles inclusive, 0 = not checked
   } vec_t;

   vec_t vecs[10];

   task automatic run_vec(input vec_t v, input int glitch_at);
      int   cyc;
      res_t exp;
      sbq.push_back('{rx: v.rx, ry: v.ry, inf: v.inf});
      for (int i = 0; i < int'(v.nops); i++) opq.push_back(v.mask[i]);
      k     = v.k;
      start = 1'b1;
      cyc   = 1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 2;
      check($sformatf("busy after start k=%0d", v.k), 32'(busy), 32'd1);
      while (!done && cyc < 300) begin
         if (cyc == glitch_at) begin
            // A start with different k and P while busy must change nothing.
            start = 1'b1;
            k     = '0;
            px    = 8'd11;
            py    = 8'd22;
         end else begin
            start = 1'b0;
            px    = 8'd3;
            py    = 8'd6;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      px    = 8'd3;
      py    = 8'd6;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL timeout k=%0d: got no done after %0d cycles expected done", v.k, cyc);
         sbq.delete();
         opq.delete();
      end else begin
         exp = sbq.pop_front();
         check($sformatf("rx k=%0d", v.k), 32'(rx), 32'(exp.rx));
         check($sformatf("ry k=%0d", v.k), 32'(ry), 32'(exp.ry));
         check($sformatf("r_inf k=%0d", v.k), 32'(r_inf), 32'(exp.inf));
         check($sformatf("busy at done k=%0d", v.k), 32'(busy), 32'd0);
         if (v.lat != 0)
            check($sformatf("latency k=%0d", v.k), 32'(cyc), 32'(v.lat));
         check($sformatf("ops left k=%0d", v.k), 32'(opq.size()), 32'd0);
         @(negedge clk);
         check($sformatf("done one cycle k=%0d", v.k), 32'(done), 32'd0);
      end
   endtask

   initial begin
      int seen;
      int done_seen;
      int busy_seen;

      reset = 1'b1;
      start = 1'b0;
      k     = '0;
      px    = 8'd3;
      py    = 8'd6;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("reset busy",     32'(busy),     32'd0);
      check("reset done",     32'(done),     32'd0);
      check("reset r_inf",    32'(r_inf),    32'd1);
      check("reset rx",       32'(rx),       32'd0);
      check("reset ry",       32'(ry),       32'd0);
      check("reset op_start", 32'(op_start), 32'd0);
      check("reset op_dbl",   32'(op_dbl),   32'd0);
      check("reset op_ax",    32'(op_ax),    32'd0);

      //           k          rx          ry        inf    nops   mask        lat
      vecs[0] = '{k: 8'd0,   rx: 8'd0,  ry: 8'd0,  inf: 1'b1, nops: 4'd0,  mask: 16'h000, lat: 8'd26};
      vecs[1] = '{k: 8'd1,   rx: 8'd3,  ry: 8'd6,  inf: 1'b0, nops: 4'd0,  mask: 16'h000, lat: 8'd26};
      vecs[2] = '{k: 8'd2,   rx: 8'd80, ry: 8'd10, inf: 1'b0, nops: 4'd1,  mask: 16'h001, lat: 8'd0};
      vecs[3] = '{k: 8'd3,   rx: 8'd80, ry: 8'd87, inf: 1'b0, nops: 4'd2,  mask: 16'h001, lat: 8'd0};
      vecs[4] = '{k: 8'd4,   rx: 8'd3,  ry: 8'd91, inf: 1'b0, nops: 4'd2,  mask: 16'h003, lat: 8'd0};
      vecs[5] = '{k: 8'd5,   rx: 8'd0,  ry: 8'd0,  inf: 1'b1, nops: 4'd2,  mask: 16'h003, lat: 8'd0};
      vecs[6] = '{k: 8'd6,   rx: 8'd3,  ry: 8'd6,  inf: 1'b0, nops: 4'd3,  mask: 16'h005, lat: 8'd0};
      vecs[7] = '{k: 8'd7,   rx: 8'd80, ry: 8'd10, inf: 1'b0, nops: 4'd4,  mask: 16'h00D, lat: 8'd0};
      vecs[8] = '{k: 8'd10,  rx: 8'd0,  ry: 8'd0,  inf: 1'b1, nops: 4'd2,  mask: 16'h003, lat: 8'd0};
      vecs[9] = '{k: 8'd255, rx: 8'd0,  ry: 8'd0,  inf: 1'b1, nops: 4'd10, mask: 16'h3BD, lat: 8'd0};

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i], 0);
         repeat (2) @(negedge clk);
      end

      // start pulsed while busy: same answer as a clean k = 3 run
      run_vec(vecs[3], 5);
      repeat (2) @(negedge clk);

      // reset inside DBL_WAIT, stale op_done afterwards
      opq.push_back(1'b1);
      k     = 8'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen  = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         if (op_start) seen = 1;
         else @(negedge clk);
      end
      check("op_start seen before reset", 32'(seen), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid-op reset busy",   32'(busy),   32'd0);
      check("mid-op reset r_inf",  32'(r_inf),  32'd1);
      check("mid-op reset rx",     32'(rx),     32'd0);
      check("mid-op reset op_dbl", 32'(op_dbl), 32'd0);
      check("mid-op reset op_ax",  32'(op_ax),  32'd0);
      done_seen = 0;
      busy_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) done_seen++;
         if (busy) busy_seen++;
      end
      check("no done after stale op_done", 32'(done_seen), 32'd0);
      check("idle after stale op_done",    32'(busy_seen), 32'd0);
      check("stale op queue empty",        32'(opq.size()), 32'd0);

      run_vec(vecs[3], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
